// File: rtl/tt_char_pkg.sv
// Shared constants and FSM state type for the truth-table characterizer.
package tt_char_pkg;

    localparam int unsigned N_ROWS = 8;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CONFIRM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tt_characterizer.sv
// Walks all eight input rows of a 3-input circuit, samples its output twice
// per row and assembles the measured truth-table code.
module tt_characterizer
    import tt_char_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] expected,
    input  logic              dut_out,
    output logic              dut_in1,
    output logic              dut_in2,
    output logic              dut_in3,
    output logic [CODE_W-1:0] tt_code,
    output logic              match,
    output logic              unstable,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_ROW    = IDX_W'(N_ROWS - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] exp_q, exp_d;
    logic [CODE_W-1:0] tt_code_q, tt_code_d;
    logic              s0_q, s0_d;
    logic              match_q, match_d;
    logic              unstable_q, unstable_d;
    logic              done_q, done_d;
    logic              out_sync;
    logic              drive;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dut_out),
        .q_o   (out_sync)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            code_q     <= '0;
            exp_q      <= '0;
            tt_code_q  <= '0;
            s0_q       <= 1'b0;
            match_q    <= 1'b0;
            unstable_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            code_q     <= code_d;
            exp_q      <= exp_d;
            tt_code_q  <= tt_code_d;
            s0_q       <= s0_d;
            match_q    <= match_d;
            unstable_q <= unstable_d;
            done_q     <= done_d;
        end
    end

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        code_d     = code_q;
        exp_d      = exp_q;
        tt_code_d  = tt_code_q;
        s0_d       = s0_q;
        match_d    = match_q;
        unstable_d = unstable_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    exp_d      = expected;
                    idx_d      = '0;
                    cnt_d      = '0;
                    code_d     = '0;
                    unstable_d = 1'b0;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                s0_d    = out_sync;
                state_d = ST_CONFIRM;
            end
            ST_CONFIRM: begin
                if (out_sync != s0_q) begin
                    unstable_d = 1'b1;
                end
                code_d[idx_q] = s0_q;
                if (idx_q == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                tt_code_d = code_q;
                match_d   = (code_q == exp_q);
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            tt_code_d = tt_code_q;
            match_d   = match_q;
            done_d    = 1'b0;
        end
    end

    assign drive    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) ||
                      (state_q == ST_CONFIRM);
    assign dut_in1  = drive & idx_q[2];
    assign dut_in2  = drive & idx_q[1];
    assign dut_in3  = drive & idx_q[0];
    assign tt_code  = tt_code_q;
    assign match    = match_q;
    assign unstable = unstable_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_tt_characterizer.sv
// Directed bench for tt_characterizer: full runs, glitch, abort, reset.
module tb_tt_characterizer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       glitch = 1'b0;
    int         sel = 0;

    logic       in1, in2, in3, dout;
    logic [7:0] tt_code;
    logic       match, unstable, busy, done;
    logic       b_in1, b_in2, b_in3, b_dout;
    logic [7:0] b_tt_code;
    logic       b_match, b_unstable, b_busy, b_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_at;
    logic ab_busy;
    logic [2:0] ab_din;

    always #5 clk = ~clk;

    function automatic logic model(input int s, input logic [2:0] r);
        if (s == 0) return (r == 3'd3) || (r == 3'd4);
        return 1'b0;
    endfunction

    assign dout   = model(sel, {in1, in2, in3}) ^ glitch;
    assign b_dout = model(0, {b_in1, b_in2, b_in3});

    tt_characterizer #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .dut_out(dout),
        .dut_in1(in1), .dut_in2(in2), .dut_in3(in3),
        .tt_code(tt_code), .match(match), .unstable(unstable),
        .busy(busy), .done(done)
    );

    tt_characterizer #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .expected(expected), .dut_out(b_dout),
        .dut_in1(b_in1), .dut_in2(b_in2), .dut_in3(b_in3),
        .tt_code(b_tt_code), .match(b_match), .unstable(b_unstable),
        .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edge n counts rising edges after the one that samples start.
    // Controls for edge n are applied #1 after edge n-1.
    task automatic run(input int which, input logic [7:0] exp_code, input int s,
                       input int glitch_at, input int abort_at, input int spulse_at,
                       input int expchg_at);
        logic d;
        done_at  = -1;
        sel      = s;
        expected = exp_code;
        @(negedge clk);
        if (which == 0) start = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int n = 1; n <= 120; n++) begin
            abort  = (n == abort_at);
            start  = (which == 0) && (n == spulse_at);
            glitch = (glitch_at > 0) && (n >= glitch_at) && (n < glitch_at + 3);
            if (n == expchg_at) expected = ~exp_code;
            @(posedge clk); #1;
            d = (which == 0) ? done : b_done;
            if (d && done_at < 0) done_at = n;
            if (n == abort_at) begin
                ab_busy = busy;
                ab_din  = {in1, in2, in3};
            end
            if (done_at >= 0 && n > done_at + 2) break;
        end
        abort    = 1'b0;
        start    = 1'b0;
        glitch   = 1'b0;
        expected = exp_code;
    endtask

    initial begin
        #12;
        check("reset_tt_code", 32'(tt_code), 32'h00);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_din", 32'({in1, in2, in3}), 0);
        check("reset_match", 32'(match), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Constant-0 circuit.
        run(0, 8'h00, 1, 0, 0, 0, 0);
        check("c0_done_edge", 32'(done_at), 49);
        check("c0_tt_code", 32'(tt_code), 32'h00);
        check("c0_match", 32'(match), 1);

        // Rows 3,4 true; start pulse and expected change mid-run are ignored.
        run(0, 8'h18, 0, 0, 0, 10, 5);
        check("a_done_edge", 32'(done_at), 49);
        check("a_tt_code", 32'(tt_code), 32'h18);
        check("a_match", 32'(match), 1);
        check("a_unstable", 32'(unstable), 0);
        check("a_busy_after", 32'(busy), 0);

        // Wrong reference.
        run(0, 8'h19, 0, 0, 0, 0, 0);
        check("b_tt_code", 32'(tt_code), 32'h18);
        check("b_match", 32'(match), 0);

        // Output flips between the two samples of row 5.
        run(0, 8'h18, 0, 34, 0, 0, 0);
        check("g_done_edge", 32'(done_at), 49);
        check("g_unstable", 32'(unstable), 1);
        check("g_tt_code", 32'(tt_code), 32'h18);
        check("g_match", 32'(match), 1);

        // Abort during row 3 settle.
        run(0, 8'h00, 1, 0, 20, 0, 0);
        check("ab_done", 32'(done_at), 32'hFFFF_FFFF);
        check("ab_busy", 32'(ab_busy), 0);
        check("ab_din", 32'(ab_din), 0);
        check("ab_tt_code", 32'(tt_code), 32'h18);
        check("ab_match", 32'(match), 1);

        // Abort coinciding with the CONFIRM->DONE transition of row 7.
        run(0, 8'h00, 1, 0, 48, 0, 0);
        check("abd_done", 32'(done_at), 32'hFFFF_FFFF);
        check("abd_tt_code", 32'(tt_code), 32'h18);

        // start and abort together in IDLE.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_idle_busy", 32'(busy), 0);

        // Reset asserted mid-run during row 6.
        sel      = 0;
        expected = 8'h18;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        check("pre_rst_din", 32'({in1, in2, in3}), 32'd6);
        rst_n = 1'b0;
        #1;
        check("rst_din", 32'({in1, in2, in3}), 0);
        check("rst_tt_code", 32'(tt_code), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_match", 32'(match), 0);
        check("rst_unstable", 32'(unstable), 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int act;
            act = 0;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk); #1;
                if (busy || done || in1 || in2 || in3) act++;
            end
            check("post_rst_idle", 32'(act), 0);
        end

        // Shorter settle time.
        run(1, 8'h18, 0, 0, 0, 0, 0);
        check("s2_done_edge", 32'(done_at), 33);
        check("s2_tt_code", 32'(b_tt_code), 32'h18);
        check("s2_match", 32'(b_match), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
